fifo_sync: RTL and testbench

Single-clock successor to the team's dual-clock FIFO, for buffering between blocks that share one clock domain. It adds the almost-full and almost-empty logic that the earlier block lacks, plus an occupancy count, a synchronous flush and a sticky overflow flag. Depth and width are parametrised. The data in/out valid/ack interfaces match the dual-clock FIFO, so the two blocks are interchangeable at the port level.

---
 rtl/fifo_pkg.sv | 23 ++
 rtl/fifo_ram.sv | 28 ++
 rtl/fifo_sync.sv | 124 ++++++++++++
 tb/tb_fifo_sync.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared helpers for the FIFO family: address-width calculation and the legal
// parameter ranges common to the single- and dual-clock FIFOs.
package fifo_pkg;

    localparam int FIFO_MIN_DEPTH = 4;
    localparam int FIFO_MAX_DEPTH = 1024;
    localparam int FIFO_MIN_WIDTH = 1;
    localparam int FIFO_MAX_WIDTH = 1024;

    // Ceiling log2; exact for the power-of-two depths the FIFOs accept.
    function automatic int clogb2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result = result + 1;
            v = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage: synchronous write, asynchronous read.
// Contents are deliberately left unreset.
module fifo_ram
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int BUFFER_SIZE = 16,
    localparam int ADDRESS_WIDTH = clogb2(BUFFER_SIZE)
) (
    input  logic                     clock,
    input  logic                     write_enable,
    input  logic [ADDRESS_WIDTH-1:0] write_address,
    input  logic [DATA_WIDTH-1:0]    write_data,
    input  logic [ADDRESS_WIDTH-1:0] read_address,
    output logic [DATA_WIDTH-1:0]    read_data
);

    logic [DATA_WIDTH-1:0] memory [BUFFER_SIZE];

    always_ff @(posedge clock) begin
        if (write_enable) begin
            memory[write_address] <= write_data;
        end
    end

    assign read_data = memory[read_address];

endmodule

// File: rtl/fifo_sync.sv
// Single-clock first-word-fall-through FIFO with occupancy count, almost
// flags, synchronous flush and a sticky overflow flag.
module fifo_sync
    import fifo_pkg::*;
#(
    parameter int BUFFER_SIZE = 16,
    parameter int DATA_WIDTH = 32,
    parameter int ALMOST_FULL_LEVEL = 12,
    parameter int ALMOST_EMPTY_LEVEL = 4,
    localparam int ADDRESS_WIDTH = clogb2(BUFFER_SIZE)
) (
    input  logic                     clock,
    input  logic                     rst,
    input  logic [DATA_WIDTH-1:0]    data_in,
    input  logic                     data_in_valid,
    output logic                     data_in_full,
    output logic [DATA_WIDTH-1:0]    data_out,
    output logic                     data_out_valid,
    input  logic                     data_out_ack,
    input  logic                     flush,
    input  logic                     clear_overflow,
    output logic [ADDRESS_WIDTH:0]   fill_level,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic                     overflow
);

    localparam int LW = ADDRESS_WIDTH + 1;
    localparam logic [LW-1:0] FULL_LEVEL = LW'(BUFFER_SIZE);
    localparam logic [LW-1:0] AF_LEVEL   = LW'(ALMOST_FULL_LEVEL);
    localparam logic [LW-1:0] AE_LEVEL   = LW'(ALMOST_EMPTY_LEVEL);

    generate
        if (BUFFER_SIZE < FIFO_MIN_DEPTH || BUFFER_SIZE > FIFO_MAX_DEPTH ||
            (BUFFER_SIZE & (BUFFER_SIZE - 1)) != 0) begin : g_bad_depth
            $error("fifo_sync: BUFFER_SIZE must be a power of two in 4..1024");
        end
        if (DATA_WIDTH < FIFO_MIN_WIDTH || DATA_WIDTH > FIFO_MAX_WIDTH) begin : g_bad_width
            $error("fifo_sync: DATA_WIDTH must be in 1..1024");
        end
        if (ALMOST_FULL_LEVEL < 1 || ALMOST_FULL_LEVEL > BUFFER_SIZE - 1) begin : g_bad_af
            $error("fifo_sync: ALMOST_FULL_LEVEL must be in 1..BUFFER_SIZE-1");
        end
        if (ALMOST_EMPTY_LEVEL < 1 || ALMOST_EMPTY_LEVEL > BUFFER_SIZE - 1) begin : g_bad_ae
            $error("fifo_sync: ALMOST_EMPTY_LEVEL must be in 1..BUFFER_SIZE-1");
        end
    endgenerate

    logic [ADDRESS_WIDTH-1:0] wr_ptr;
    logic [ADDRESS_WIDTH-1:0] rd_ptr;
    logic [LW-1:0]            level_nxt;
    logic                     push;
    logic                     pop;

    // Handshakes qualify on the registered flags, so a full FIFO refuses a
    // write even when a pop frees a slot in the same cycle.
    assign push = data_in_valid & ~data_in_full;
    assign pop  = data_out_ack & data_out_valid;

    always_comb begin
        level_nxt = fill_level;
        if (flush) begin
            level_nxt = '0;
        end else if (push && !pop) begin
            level_nxt = fill_level + LW'(1);
        end else if (pop && !push) begin
            level_nxt = fill_level - LW'(1);
        end
    end

    fifo_ram #(
        .DATA_WIDTH  (DATA_WIDTH),
        .BUFFER_SIZE (BUFFER_SIZE)
    ) u_ram (
        .clock         (clock),
        .write_enable  (push & ~flush),
        .write_address (wr_ptr),
        .write_data    (data_in),
        .read_address  (rd_ptr),
        .read_data     (data_out)
    );

    // Flags are computed from the next level so they stay coherent with fill_level.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            fill_level     <= '0;
            data_in_full   <= 1'b0;
            data_out_valid <= 1'b0;
            almost_full    <= 1'b0;
            almost_empty   <= 1'b1;
        end else begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + ADDRESS_WIDTH'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + ADDRESS_WIDTH'(1);
                end
            end
            fill_level     <= level_nxt;
            data_in_full   <= (level_nxt == FULL_LEVEL);
            data_out_valid <= (level_nxt != '0);
            almost_full    <= (level_nxt >= AF_LEVEL);
            almost_empty   <= (level_nxt <= AE_LEVEL);
        end
    end

    // Sticky overflow: a refused write sets it, set beats clear, flush leaves it alone.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (data_in_valid && data_in_full) begin
            overflow <= 1'b1;
        end else if (clear_overflow) begin
            overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fifo_sync.sv
// Scoreboard bench for fifo_sync: a queue model tracks contents, level and
// flags, and every DUT output is compared against it each cycle.
module tb_fifo_sync;

    localparam int DEPTH = 16;
    localparam int AF    = 12;
    localparam int AE    = 4;

    logic        clock;
    logic        rst;
    logic [31:0] data_in;
    logic        data_in_valid;
    logic        data_in_full;
    logic [31:0] data_out;
    logic        data_out_valid;
    logic        data_out_ack;
    logic        flush;
    logic        clear_overflow;
    logic [4:0]  fill_level;
    logic        almost_full;
    logic        almost_empty;
    logic        overflow;

    fifo_sync #(
        .BUFFER_SIZE        (DEPTH),
        .DATA_WIDTH         (32),
        .ALMOST_FULL_LEVEL  (AF),
        .ALMOST_EMPTY_LEVEL (AE)
    ) dut (
        .clock          (clock),
        .rst            (rst),
        .data_in        (data_in),
        .data_in_valid  (data_in_valid),
        .data_in_full   (data_in_full),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .data_out_ack   (data_out_ack),
        .flush          (flush),
        .clear_overflow (clear_overflow),
        .fill_level     (fill_level),
        .almost_full    (almost_full),
        .almost_empty   (almost_empty),
        .overflow       (overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int          n_vec;
    int          n_err;
    logic [31:0] sb [$];
    logic        m_ovf;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic check_state(input string ctx);
        int lvl;
        lvl = sb.size();
        check({ctx, ".fill_level"},   32'(fill_level),     32'(lvl));
        check({ctx, ".valid"},        32'(data_out_valid), 32'(lvl != 0));
        check({ctx, ".full"},         32'(data_in_full),   32'(lvl == DEPTH));
        check({ctx, ".almost_full"},  32'(almost_full),    32'(lvl >= AF));
        check({ctx, ".almost_empty"}, 32'(almost_empty),   32'(lvl <= AE));
        check({ctx, ".overflow"},     32'(overflow),       32'(m_ovf));
        if (lvl != 0) begin
            check({ctx, ".data_out"}, data_out, sb[0]);
        end
    endtask

    // One clock: drive inputs, advance the model, compare after the edge.
    task automatic cycle(input string ctx, input logic v, input logic [31:0] d,
                         input logic a, input logic fl, input logic clr);
        logic m_full;
        logic m_push;
        logic m_pop;
        data_in        = d;
        data_in_valid  = v;
        data_out_ack   = a;
        flush          = fl;
        clear_overflow = clr;
        m_full = (sb.size() == DEPTH);
        m_push = v && !m_full && !fl;
        m_pop  = a && (sb.size() != 0) && !fl;
        if (v && m_full) m_ovf = 1'b1;
        else if (clr)    m_ovf = 1'b0;
        @(posedge clock);
        #1;
        if (fl) begin
            sb.delete();
        end else begin
            if (m_pop)  void'(sb.pop_front());
            if (m_push) sb.push_back(d);
        end
        data_in_valid  = 1'b0;
        data_out_ack   = 1'b0;
        flush          = 1'b0;
        clear_overflow = 1'b0;
        check_state(ctx);
    endtask

    task automatic check_reset_outputs(input string ctx);
        check({ctx, ".fill_level"},   32'(fill_level),     32'd0);
        check({ctx, ".valid"},        32'(data_out_valid), 32'd0);
        check({ctx, ".full"},         32'(data_in_full),   32'd0);
        check({ctx, ".almost_full"},  32'(almost_full),    32'd0);
        check({ctx, ".almost_empty"}, 32'(almost_empty),   32'd1);
        check({ctx, ".overflow"},     32'(overflow),       32'd0);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        m_ovf = 1'b0;
        rst            = 1'b1;
        data_in        = '0;
        data_in_valid  = 1'b0;
        data_out_ack   = 1'b0;
        flush          = 1'b0;
        clear_overflow = 1'b0;
        #1;
        check_reset_outputs("reset");
        @(posedge clock);
        #1;
        rst = 1'b0;
        check_reset_outputs("post_reset");

        // Fill to full with 0..15, no ack.
        for (int i = 0; i < DEPTH; i++) cycle("fill", 1'b1, 32'(i), 1'b0, 1'b0, 1'b0);

        // Full with valid and ack together: pop proceeds, push refused, overflow set.
        cycle("full_va", 1'b1, 32'hAA, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 15; i++) cycle("drain", 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

        // Streaming at level 3 across pointer wrap.
        for (int i = 0; i < 3; i++) cycle("pre3", 1'b1, 32'h100 + 32'(i), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) cycle("stream", 1'b1, 32'h200 + 32'(i), 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle("post3", 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

        // Single word latency, then ack it.
        cycle("single", 1'b1, 32'h5, 1'b0, 1'b0, 1'b0);
        cycle("single_ack", 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        cycle("empty_ack", 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

        // Flush at level 10 with a concurrent write; overflow is still set here.
        for (int i = 0; i < 10; i++) cycle("pre_flush", 1'b1, 32'h300 + 32'(i), 1'b0, 1'b0, 1'b0);
        cycle("flush", 1'b1, 32'hBEEF, 1'b0, 1'b1, 1'b0);
        cycle("after_flush", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

        // Overflow clear, then set and clear in the same cycle while full.
        cycle("clr_ovf", 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < DEPTH; i++) cycle("refill", 1'b1, 32'h400 + 32'(i), 1'b0, 1'b0, 1'b0);
        cycle("set_vs_clr", 1'b1, 32'hDEAD, 1'b0, 1'b0, 1'b1);
        cycle("clr_again", 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        cycle("flush2", 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);

        // Asynchronous reset mid-burst, between clock edges.
        for (int i = 0; i < 6; i++) cycle("burst", 1'b1, 32'h500 + 32'(i), 1'b0, 1'b0, 1'b0);
        #1;
        rst = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        #1;
        rst = 1'b0;
        sb.delete();
        m_ovf = 1'b0;
        cycle("after_rst", 1'b1, 32'h77, 1'b0, 1'b0, 1'b0);
        cycle("after_rst_ack", 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
